// File: rtl/aes_sched_pkg.sv
// Shared definitions for the AES job scheduler.
//   OP_ENC / OP_DEC : request opcode encoding (req_op, rsp_op)
//   sched_state_t   : scheduler FSM state encoding
//   clog2()         : elaboration-time ceiling log2 for derived widths
package aes_sched_pkg;

    localparam logic OP_ENC = 1'b0;
    localparam logic OP_DEC = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } sched_state_t;

    // Number of bits needed to index 'value' distinct items (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   eligible  : per-requester candidates for this cycle
//   ptr       : index of the last winner; search starts at ptr+1 and wraps
//   grant     : one-hot winner (all zero when nothing is eligible)
//   grant_idx : binary index of the winner (0 when nothing is eligible)
// Double-vector scheme: {eligible, eligible & above_ptr} is scanned from the
// LSB, so a candidate above the pointer wins first, otherwise the lowest
// candidate in the upper copy wins, which is the wrap-around case.
module rr_arbiter
    import aes_sched_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [N-1:0]   above_ptr;
    logic [2*N-1:0] dbl;
    logic           found;

    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // so no path leaves a value held and no latch is inferred.
        above_ptr = '0;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;

        for (int i = 0; i < N; i++) begin
            above_ptr[i] = (i > int'(ptr));
        end

        dbl = {eligible, eligible & above_ptr};

        for (int i = 0; i < 2 * N; i++) begin
            if (dbl[i] && !found) begin
                found            = 1'b1;
                grant[i % N]     = 1'b1;
                grant_idx        = IW'(i % N);
            end
        end
    end

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one AES core between NUM_REQ requesters.
//   clk, rst                 : clock (rising edge), async active-low reset
//   req_valid/op/data/key    : per-requester job requests (flattened buses)
//   req_ready                : one-hot accept, only while idle
//   aes_we/aes_re            : one-cycle encrypt/decrypt strobe to the core
//   aes_data/aes_key         : operands to the core, held until the next job
//   aes_enc_data/dec_data    : core results, valid CORE_LAT cycles after strobe
//   rsp_valid/ready/data/id/op : tagged result handshake
//   fifo_count               : entries held in the core's ciphertext FIFO
//   busy                     : high while a job is in flight
// Flow: IDLE (grant) -> ISSUE (strobe) -> WAIT (CORE_LAT cycles) -> RESP.
// Encrypts are only granted when the core FIFO has room and decrypts only
// when it holds an entry, so fifo_count cannot leave 0..FIFO_DEPTH.
module aes_job_scheduler
    import aes_sched_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_W     = 64,
    parameter  int CORE_LAT   = 1,
    parameter  int FIFO_DEPTH = 16,
    localparam int IDW        = clog2(NUM_REQ),
    localparam int CNTW       = clog2(FIFO_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*DATA_W-1:0] req_key,
    output logic                      aes_we,
    output logic                      aes_re,
    output logic [DATA_W-1:0]         aes_data,
    output logic [DATA_W-1:0]         aes_key,
    input  logic [DATA_W-1:0]         aes_enc_data,
    input  logic [DATA_W-1:0]         aes_dec_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [IDW-1:0]            rsp_id,
    output logic                      rsp_op,
    output logic [CNTW-1:0]           fifo_count,
    output logic                      busy
);

    localparam int WCW = clog2(CORE_LAT + 1);

    sched_state_t       state;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     id_q;
    logic               op_q;
    logic [WCW-1:0]     wait_cnt;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_idx;

    // A requester may only win if its op cannot over- or under-run the core FIFO.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                eligible[i] = (req_op[i] == OP_DEC) ? (fifo_count != '0)
                                                    : (fifo_count < CNTW'(FIFO_DEPTH));
            end
        end
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .eligible  (eligible),
        .ptr       (rr_ptr),
        .grant     (gnt),
        .grant_idx (gnt_idx)
    );

    assign req_ready = (state == S_IDLE) ? gnt : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            rr_ptr     <= IDW'(NUM_REQ - 1);
            id_q       <= '0;
            op_q       <= OP_ENC;
            wait_cnt   <= '0;
            aes_we     <= 1'b0;
            aes_re     <= 1'b0;
            aes_data   <= '0;
            aes_key    <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= '0;
            rsp_op     <= OP_ENC;
            fifo_count <= '0;
            busy       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // reads the pre-edge value of every other register.
            case (state)
                S_IDLE: begin
                    if (|gnt) begin
                        aes_data <= req_data[int'(gnt_idx)*DATA_W +: DATA_W];
                        aes_key  <= req_key[int'(gnt_idx)*DATA_W +: DATA_W];
                        op_q     <= req_op[gnt_idx];
                        id_q     <= gnt_idx;
                        rr_ptr   <= gnt_idx;
                        // Strobes are registered so they are high exactly
                        // during ISSUE.
                        aes_we   <= (req_op[gnt_idx] == OP_ENC);
                        aes_re   <= (req_op[gnt_idx] == OP_DEC);
                        busy     <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    aes_we   <= 1'b0;
                    aes_re   <= 1'b0;
                    if (op_q == OP_ENC) begin
                        fifo_count <= fifo_count + CNTW'(1);
                    end else begin
                        fifo_count <= fifo_count - CNTW'(1);
                    end
                    wait_cnt <= WCW'(CORE_LAT);
                    state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (wait_cnt == WCW'(1)) begin
                        rsp_data  <= (op_q == OP_DEC) ? aes_dec_data : aes_enc_data;
                        rsp_id    <= id_q;
                        rsp_op    <= op_q;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - WCW'(1);
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // Eligibility gating makes these unreachable; they catch a broken guard.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        (state == S_ISSUE && op_q == OP_ENC) |-> (fifo_count < CNTW'(FIFO_DEPTH)));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        (state == S_ISSUE && op_q == OP_DEC) |-> (fifo_count != '0));

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Self-checking bench for aes_job_scheduler. A small behavioural AES core
// stand-in (reversible mix of data and key, ciphertext FIFO, one-cycle
// output register) is driven by the scheduler's strobes. Inputs change on
// the falling edge; outputs are sampled 1-2 time units after it.
module tb_aes_job_scheduler;
    import aes_sched_pkg::*;

    localparam int NUM_REQ    = 4;
    localparam int DATA_W     = 64;
    localparam int CORE_LAT   = 1;
    localparam int FIFO_DEPTH = 16;
    localparam int IDW        = 2;
    localparam int CNTW       = 5;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_op;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*DATA_W-1:0] req_key;
    logic                      aes_we;
    logic                      aes_re;
    logic [DATA_W-1:0]         aes_data;
    logic [DATA_W-1:0]         aes_key;
    logic [DATA_W-1:0]         aes_enc_data;
    logic [DATA_W-1:0]         aes_dec_data;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic [IDW-1:0]            rsp_id;
    logic                      rsp_op;
    logic [CNTW-1:0]           fifo_count;
    logic                      busy;

    always #5 clk = ~clk;

    aes_job_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .DATA_W     (DATA_W),
        .CORE_LAT   (CORE_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_data     (req_data),
        .req_key      (req_key),
        .aes_we       (aes_we),
        .aes_re       (aes_re),
        .aes_data     (aes_data),
        .aes_key      (aes_key),
        .aes_enc_data (aes_enc_data),
        .aes_dec_data (aes_dec_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_id       (rsp_id),
        .rsp_op       (rsp_op),
        .fifo_count   (fifo_count),
        .busy         (busy)
    );

    // ---------------- core stand-in ----------------
    localparam logic [63:0] MIX = 64'h9E3779B97F4A7C15;

    function automatic logic [63:0] enc_fn(input logic [63:0] d, input logic [63:0] k);
        return ((d ^ k) + MIX) ^ {k[31:0], k[63:32]};
    endfunction

    function automatic logic [63:0] dec_fn(input logic [63:0] c, input logic [63:0] k);
        return ((c ^ {k[31:0], k[63:32]}) - MIX) ^ k;
    endfunction

    logic [63:0] core_q[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_q.delete();
        end else begin
            if (aes_we) begin
                aes_enc_data <= enc_fn(aes_data, aes_key);
                core_q.push_back(enc_fn(aes_data, aes_key));
            end
            if (aes_re && core_q.size() > 0) begin
                aes_dec_data <= dec_fn(core_q[0], aes_key);
                void'(core_q.pop_front());
            end
        end
    end

    // ---------------- bookkeeping ----------------
    typedef struct {
        int          id;
        logic        op;
        logic [63:0] data;
        logic [63:0] key;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        int          id;
        logic        op;
        logic [63:0] data;
    } rsp_t;

    rsp_t               rsp_q[$];
    int                 grant_q[$];
    int                 we_cnt;
    int                 re_cnt;
    int                 n_err;
    int                 n_checks;
    logic [NUM_REQ-1:0] pending_clear;

    logic [63:0] p_c [6];
    logic [63:0] k_c [6];
    vec_t        rt  [6];
    vec_t        fill;
    logic        match;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic int get_grant(input int k);
        return (k < grant_q.size()) ? grant_q[k] : -1;
    endfunction

    function automatic rsp_t get_rsp(input int k);
        rsp_t r;
        r.id   = -1;
        r.op   = 1'bx;
        r.data = 'x;
        if (k < rsp_q.size()) r = rsp_q[k];
        return r;
    endfunction

    task automatic set_req(input int id, input logic op, input logic [63:0] d, input logic [63:0] k);
        req_op[id]                    = op;
        req_data[id*DATA_W +: DATA_W] = d;
        req_key[id*DATA_W +: DATA_W]  = k;
        req_valid[id]                 = 1'b1;
    endtask

    // Samples what the coming rising edge will see, advances to the next
    // falling edge, then withdraws requests that were just accepted.
    task automatic tick();
        rsp_t r;
        #1;
        if (req_ready != '0) begin
            for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) grant_q.push_back(i);
            pending_clear = req_ready;
        end
        if (rsp_valid && rsp_ready) begin
            r.id   = int'(rsp_id);
            r.op   = rsp_op;
            r.data = rsp_data;
            rsp_q.push_back(r);
        end
        if (aes_we) we_cnt++;
        if (aes_re) re_cnt++;
        @(negedge clk);
        req_valid     = req_valid & ~pending_clear;
        pending_clear = '0;
        #1;
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (rsp_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        check({name, "_responses"}, 64'(rsp_q.size()), 64'(n));
    endtask

    task automatic run_vec(input vec_t v, input string name, output logic ok);
        rsp_t r;
        rsp_q.delete();
        grant_q.delete();
        set_req(v.id, v.op, v.data, v.key);
        run_until(1, 20, name);
        r = get_rsp(0);
        check({name, "_id"},   64'(r.id), 64'(v.id));
        check({name, "_op"},   64'(r.op), 64'(v.op));
        check({name, "_data"}, r.data,    v.exp);
        ok = (r.data === v.exp);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        rsp_t r;

        n_err         = 0;
        n_checks      = 0;
        we_cnt        = 0;
        re_cnt        = 0;
        pending_clear = '0;
        req_valid     = '0;
        req_op        = '0;
        req_data      = '0;
        req_key       = '0;
        rsp_ready     = 1'b1;
        rst           = 1'b0;

        p_c[0] = 64'h1111_2222_3333_4444;  k_c[0] = 64'hA0A1_A2A3_A4A5_A6A7;
        p_c[1] = 64'h5555_6666_7777_8888;  k_c[1] = 64'hB0B1_B2B3_B4B5_B6B7;
        p_c[2] = 64'h9999_AAAA_BBBB_CCCC;  k_c[2] = 64'hC0C1_C2C3_C4C5_C6C7;
        p_c[3] = 64'hDDDD_EEEE_FFFF_0000;  k_c[3] = 64'hD0D1_D2D3_D4D5_D6D7;
        p_c[4] = 64'h0F0F_0F0F_F0F0_F0F0;  k_c[4] = 64'h1357_9BDF_2468_ACE0;
        p_c[5] = 64'hCAFE_BABE_DEAD_BEEF;  k_c[5] = 64'h0011_2233_4455_6677;

        // Round trip: three encrypts, then decrypts with matching keys return
        // the plaintexts oldest-first.
        rt[0] = '{id: 0, op: OP_ENC, data: p_c[0], key: k_c[0], exp: enc_fn(p_c[0], k_c[0])};
        rt[1] = '{id: 2, op: OP_ENC, data: p_c[1], key: k_c[1], exp: enc_fn(p_c[1], k_c[1])};
        rt[2] = '{id: 3, op: OP_ENC, data: p_c[2], key: k_c[2], exp: enc_fn(p_c[2], k_c[2])};
        rt[3] = '{id: 1, op: OP_DEC, data: 64'h0,  key: k_c[0], exp: p_c[0]};
        rt[4] = '{id: 2, op: OP_DEC, data: 64'h0,  key: k_c[1], exp: p_c[1]};
        rt[5] = '{id: 0, op: OP_DEC, data: 64'h0,  key: k_c[2], exp: p_c[2]};

        // ---- reset state ----
        @(negedge clk);
        #1;
        check("reset_rsp_valid",  64'(rsp_valid),  64'd0);
        check("reset_busy",       64'(busy),       64'd0);
        check("reset_fifo_count", 64'(fifo_count), 64'd0);
        check("reset_aes_we",     64'(aes_we),     64'd0);
        check("reset_aes_re",     64'(aes_re),     64'd0);
        check("reset_req_ready",  64'(req_ready),  64'd0);
        check("reset_rsp_data",   rsp_data,        64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // ---- empty guard: decrypt with nothing in the core ----
        set_req(2, OP_DEC, 64'hDEAD_0000_0000_BEEF, 64'h0123_0000_0000_4567);
        #1;
        check("empty_req_ready", 64'(req_ready), 64'd0);
        repeat (8) tick();
        check("empty_no_grant", 64'(grant_q.size()), 64'd0);
        check("empty_no_re",    64'(re_cnt),         64'd0);
        check("empty_busy",     64'(busy),           64'd0);
        req_valid[2] = 1'b0;

        // ---- single encrypt, cycle by cycle ----
        set_req(0, OP_ENC, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1);
        #1;
        check("single_ready", 64'(req_ready), 64'b0001);
        tick();
        check("single_issue_we",   64'(aes_we), 64'd1);
        check("single_issue_re",   64'(aes_re), 64'd0);
        check("single_issue_data", aes_data,    64'h0123456789ABCDEF);
        check("single_issue_key",  aes_key,     64'h133457799BBCDFF1);
        check("single_issue_busy", 64'(busy),   64'd1);
        tick();
        check("single_wait_we",    64'(aes_we),     64'd0);
        check("single_wait_valid", 64'(rsp_valid),  64'd0);
        check("single_fifo_count", 64'(fifo_count), 64'd1);
        tick();
        check("single_rsp_valid", 64'(rsp_valid), 64'd1);
        check("single_rsp_id",    64'(rsp_id),    64'd0);
        check("single_rsp_op",    64'(rsp_op),    64'd0);
        check("single_rsp_data",  rsp_data, enc_fn(64'h0123456789ABCDEF, 64'h133457799BBCDFF1));
        tick();
        check("single_done_valid", 64'(rsp_valid),    64'd0);
        check("single_done_busy",  64'(busy),         64'd0);
        check("single_we_pulses",  64'(we_cnt),       64'd1);
        check("single_rsp_count",  64'(rsp_q.size()), 64'd1);

        // ---- backpressure ----
        rsp_q.delete();
        grant_q.delete();
        rsp_ready = 1'b0;
        set_req(3, OP_ENC, p_c[4], k_c[4]);
        c = 0;
        while (!rsp_valid && c < 20) begin
            tick();
            c++;
        end
        set_req(1, OP_ENC, p_c[5], k_c[5]);
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rsp_data",  rsp_data,       enc_fn(p_c[4], k_c[4]));
            check("bp_rsp_id",    64'(rsp_id),    64'd3);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_consumed",     64'(rsp_q.size()),   64'd1);
        check("bp_valid_low",    64'(rsp_valid),      64'd0);
        check("bp_single_grant", 64'(grant_q.size()), 64'd1);
        run_until(2, 20, "bp_next");
        r = get_rsp(1);
        check("bp_next_id",   64'(r.id), 64'd1);
        check("bp_next_data", r.data,    enc_fn(p_c[5], k_c[5]));
        check("bp_fifo_count", 64'(fifo_count), 64'd3);

        // ---- reset during WAIT ----
        set_req(2, OP_ENC, 64'h7777_0000_0000_7777, 64'h0000_8888_8888_0000);
        tick();
        tick();
        check("rw_busy_before",  64'(busy),       64'd1);
        check("rw_fifo_before",  64'(fifo_count), 64'd4);
        rst = 1'b0;
        #1;
        check("rw_rsp_valid", 64'(rsp_valid),  64'd0);
        check("rw_busy",      64'(busy),       64'd0);
        check("rw_fifo",      64'(fifo_count), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // ---- contention: pointer restarts at requester 0 ----
        rsp_q.delete();
        grant_q.delete();
        for (int i = 0; i < 4; i++) set_req(i, OP_ENC, p_c[i], k_c[i]);
        run_until(4, 60, "cont_r1");
        for (int i = 0; i < 4; i++) begin
            r = get_rsp(i);
            check("cont_r1_grant", 64'(get_grant(i)), 64'(i));
            check("cont_r1_id",    64'(r.id),         64'(i));
            check("cont_r1_data",  r.data,            enc_fn(p_c[i], k_c[i]));
        end
        rsp_q.delete();
        grant_q.delete();
        set_req(1, OP_ENC, p_c[4], k_c[4]);
        set_req(3, OP_ENC, p_c[5], k_c[5]);
        run_until(2, 30, "cont_r2");
        check("cont_r2_grant0", 64'(get_grant(0)), 64'd1);
        check("cont_r2_grant1", 64'(get_grant(1)), 64'd3);
        check("cont_fifo_count", 64'(fifo_count), 64'd6);

        // ---- full guard ----
        for (int i = 0; i < 10; i++) begin
            fill = '{id: 0, op: OP_ENC, data: 64'h1000 + 64'(i), key: 64'hA5A5_0000 + 64'(i),
                     exp: enc_fn(64'h1000 + 64'(i), 64'hA5A5_0000 + 64'(i))};
            run_vec(fill, "fill", match);
        end
        check("full_fifo_count", 64'(fifo_count), 64'(FIFO_DEPTH));
        rsp_q.delete();
        grant_q.delete();
        we_cnt = 0;
        set_req(0, OP_ENC, 64'h5A5A_5A5A_5A5A_5A5A, 64'h3C3C_3C3C_3C3C_3C3C);
        #1;
        check("full_req_ready", 64'(req_ready), 64'd0);
        repeat (6) tick();
        check("full_no_grant", 64'(grant_q.size()), 64'd0);
        check("full_no_we",    64'(we_cnt),         64'd0);
        set_req(1, OP_DEC, 64'h0, k_c[0]);
        run_until(2, 40, "full_drain");
        check("full_grant0", 64'(get_grant(0)), 64'd1);
        check("full_grant1", 64'(get_grant(1)), 64'd0);
        r = get_rsp(0);
        check("full_dec_op",   64'(r.op), 64'd1);
        check("full_dec_data", r.data,    p_c[0]);
        r = get_rsp(1);
        check("full_enc_id",   64'(r.id), 64'd0);
        check("full_enc_data", r.data,    enc_fn(64'h5A5A_5A5A_5A5A_5A5A, 64'h3C3C_3C3C_3C3C_3C3C));
        check("full_fifo_end", 64'(fifo_count), 64'(FIFO_DEPTH));

        // ---- round trip from an empty core ----
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            run_vec(rt[i], "roundtrip", match);
            if (rt[i].op == OP_DEC) $display("roundtrip %0d match=%0d", i - 3, match);
        end
        check("roundtrip_fifo_count", 64'(fifo_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_job_scheduler.md
Name: aes_job_scheduler

Overview:
- Shares one AES core (64-bit data/key, internal ciphertext FIFO driven by we/re, outputs encrypt_data/decrypt_data) between NUM_REQ requesters.
- Round-robin arbitrates requests and pulses the core's we (encrypt) or re (decrypt) for one cycle, with data and key.
- Waits the core latency, then returns the tagged result on a valid/ready response port.
- Tracks core FIFO occupancy so encrypts never overflow and decrypts never underflow the core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 64, data/key width.
- CORE_LAT, 1, cycles from the we/re sampling edge to a valid core output (≥1).
- FIFO_DEPTH, 16, core FIFO capacity in entries.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot accept; at most one bit high.
- req_op  in  NUM_REQ  per-requester op: 0 = encrypt, 1 = decrypt.
- req_data  in  NUM_REQ*DATA_W  flattened plaintext/ciphertext; requester i uses slice [i*DATA_W +: DATA_W].
- req_key  in  NUM_REQ*DATA_W  flattened keys, same slicing.
- aes_we  out  1  core write (encrypt) strobe.
- aes_re  out  1  core read (decrypt) strobe.
- aes_data  out  DATA_W  data to core.
- aes_key  out  DATA_W  key to core.
- aes_enc_data  in  DATA_W  core encrypt result.
- aes_dec_data  in  DATA_W  core decrypt result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  DATA_W  captured result.
- rsp_id  out  IDW  granted requester index; IDW = clog2(NUM_REQ).
- rsp_op  out  1  op of the response.
- fifo_count  out  clog2(FIFO_DEPTH+1)  entries held in core FIFO.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst low, async):
  - All outputs are 0; state = IDLE; fifo_count = 0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - Any in-flight job is dropped and requesters must reissue.
  - Core state is not the scheduler's concern.
- Eligibility: requester i is eligible when req_valid[i] and either:
  - req_op[i] = 0 and fifo_count < FIFO_DEPTH, or
  - req_op[i] = 1 and fifo_count > 0.
- IDLE:
  - req_ready = one-hot round-robin grant over the eligible set, searching from pointer+1 with wrap-around. This is combinational from req_valid/req_op/fifo_count.
  - On handshake (req_valid & req_ready) latch data, key, op and id; pointer <= id; go to ISSUE.
  - No eligible requester: stay in IDLE, req_ready = 0.
- ISSUE (1 cycle):
  - aes_data/aes_key = latched values; aes_we = ~op, aes_re = op.
  - fifo_count +1 on encrypt, -1 on decrypt, applied at the end of this cycle.
  - Load wait counter with CORE_LAT; go to WAIT.
- WAIT:
  - aes_we/aes_re = 0; aes_data/aes_key hold their values.
  - Counter decrements each cycle; on the cycle it reaches 1, capture rsp_data = op ? aes_dec_data : aes_enc_data, plus rsp_id and rsp_op; go to RESP.
- RESP:
  - rsp_valid = 1; rsp_data/rsp_id/rsp_op are stable until the handshake.
  - On rsp_valid & rsp_ready go to IDLE. No new grant occurs in the same cycle.
- Latency: accept at cycle T → strobe at T+1 → capture at T+1+CORE_LAT → rsp_valid from T+2+CORE_LAT. Back-to-back job throughput is one job per CORE_LAT+3 cycles with rsp_ready held high.
- Ordering: decrypts pop the core FIFO oldest-first. The scheduler never reorders; the caller pairs keys with data.
- Simultaneous requests: exactly one grant per IDLE cycle. Non-granted requesters keep valid asserted and data stable.
- Ineligible requests (full or empty FIFO) stay pending indefinitely and are never dropped.
- fifo_count saturation never occurs by construction. An assertion flags any attempted overflow or underflow.

Decomposition:
- Shared package aes_sched_pkg:
  - OP_ENC = 1'b0, OP_DEC = 1'b1.
  - State encoding IDLE/ISSUE/WAIT/RESP.
  - clog2 helper function.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: eligible vector, pointer. Output: one-hot grant plus index.
  - Purely combinational, double-vector masked priority.

Test Plan:
- Single encrypt: req0, data=64'h0123456789ABCDEF, key=64'h133457799BBCDFF1, rsp_ready=1 → one aes_we pulse at T+1; rsp_valid at T+3 with rsp_id=0, rsp_op=0, rsp_data = core output; fifo_count=1.
- Contention: all 4 requesters encrypt simultaneously and hold valid → grants in order 0,1,2,3; second round with req1 and req3 active → 1,3; fifo_count ends at 6.
- Empty/full guards:
  - Decrypt on req2 with fifo_count=0 → req_ready stays 0 and aes_re never pulses.
  - 16 encrypts then a 17th → 17th blocked while a pending decrypt on req1 is granted; the encrypt is then granted once count=15.
- Round trip: encrypt 3 packets, then decrypt 3 with matching keys → rsp_data equals the originals in order; scoreboard reports match=1 for each.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_data and rsp_id stable; no req_ready asserted; job completes on the first rsp_ready=1.
- Reset mid-WAIT: assert rst low during WAIT → immediately rsp_valid=0, busy=0, fifo_count=0; after release, req0 is granted first.
